// File: rtl/fl_vadd_mlane.sv
// fl_vadd_mlane: multi-lane binary32 vector adder, fully pipelined.
//   Each beat carries LANES independent x/y operand pairs; x and y arrive on
//   separate valid/ready channels and are joined, so a beat enters only when
//   both sides are valid and the pipeline can advance.
//   Latency (accept cycle -> out_valid cycle): 3 with OUT_REG=1, 2 with OUT_REG=0.
//   Subnormal inputs/results flush to signed zero; any NaN -> 0x7FC00000.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_x_data/valid     x operands (lane i at [32i+31:32i]), x_ready
//   in_y_data/valid     y operands, y_ready
//   in_last             end-of-vector marker, travels with the x beat
//   in_sub              (FL_VADD_SUB_EN only) 1 = x - y for this beat
//   out_data/valid/last result beat, out_ready downstream accept
//   ovf                 sticky: a lane overflowed to +/-inf from finite operands
//   beat_count          delivered result beats (wrapping)
// Optional feature macro: FL_VADD_SUB_EN (adds in_sub port).

module fl_vadd_lane #(
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        adv,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        res_ovf
);
  // Index of the highest set bit, expressed as a left-shift distance.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // ---------------- S1: unpack, flush, swap, align ----------------
  logic        sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, swap, is_nan;
  logic [7:0]  ea, eb, e_big, e_sm, d;
  logic [22:0] fa, fb;
  logic [23:0] m_big, m_sm;
  logic [4:0]  dc;
  logic [53:0] sh;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    za     = (ea == 8'd0);
    zb     = (eb == 8'd0);
    nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    is_nan = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
    // magnitude compare on flushed values so subnormals rank as zero
    swap   = (zb ? 31'd0 : b[30:0]) > (za ? 31'd0 : a[30:0]);
    e_big  = swap ? eb : ea;
    e_sm   = swap ? ea : eb;
    m_big  = swap ? (zb ? 24'd0 : {1'b1, fb}) : (za ? 24'd0 : {1'b1, fa});
    m_sm   = swap ? (za ? 24'd0 : {1'b1, fa}) : (zb ? 24'd0 : {1'b1, fb});
    d      = e_big - e_sm;
    dc     = (d > 8'd27) ? 5'd27 : d[4:0];
    // upper 27 bits are the aligned mantissa+GRS, lower 27 collect sticky
    sh     = {m_sm, 30'd0} >> dc;
  end

  logic        s1_sign, s1_zsign, s1_sub, s1_spc;
  logic [7:0]  s1_exp;
  logic [26:0] s1_ma, s1_mb;
  logic [31:0] s1_spc_val;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign    <= swap ? sb : sa;
      s1_zsign   <= sa & sb;  // exact zero is -0 only for (-0)+(-0)
      s1_sub     <= sa ^ sb;
      s1_exp     <= e_big;
      s1_ma      <= {m_big, 3'b000};
      s1_mb      <= {sh[53:28], sh[27] | (|sh[26:0])};
      s1_spc     <= nan_a | nan_b | inf_a | inf_b;
      s1_spc_val <= is_nan ? 32'h7FC0_0000 : (inf_a ? a : b);
    end
  end

  // ---------------- S2: add/sub, normalise ----------------
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb})
                 : ({1'b0, s1_ma} + {1'b0, s1_mb});
    lz  = lzc27(sum[26:0]);
    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      ne = $signed({2'b00, s1_exp}) + 10'sd1;
    end else begin
      // large left shifts only follow near-total cancellation, where sticky is 0
      nm = sum[26:0] << lz;
      ne = $signed({2'b00, s1_exp}) - $signed({5'd0, lz});
    end
  end

  logic              s2_sign, s2_zero, s2_zsign, s2_spc;
  logic signed [9:0] s2_exp;
  logic [26:0]       s2_m;
  logic [31:0]       s2_spc_val;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign    <= s1_sign;
      s2_zero    <= (sum == 28'd0);
      s2_zsign   <= s1_zsign;
      s2_exp     <= ne;
      s2_m       <= nm;
      s2_spc     <= s1_spc;
      s2_spc_val <= s1_spc_val;
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic              inc, ovf_c;
  logic [24:0]       rm;
  logic signed [9:0] re;
  logic [31:0]       res_c;

  always_comb begin
    // s2_m: [26] hidden, [25:3] fraction, [2] guard, [1:0] round|sticky
    inc   = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
    rm    = {1'b0, s2_m[26:3]} + {24'd0, inc};
    re    = s2_exp + $signed({9'd0, rm[24]});
    ovf_c = 1'b0;
    if (s2_spc)
      res_c = s2_spc_val;
    else if (s2_zero)
      res_c = {s2_zsign, 31'd0};
    else if (re >= 10'sd255) begin
      res_c = {s2_sign, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else if (re <= 10'sd0)
      res_c = {s2_sign, 31'd0};
    else
      res_c = {s2_sign, re[7:0], rm[22:0]};
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk) begin
        if (adv) begin
          res     <= res_c;
          res_ovf <= ovf_c;
        end
      end
    end else begin : g_ocomb
      assign res     = res_c;
      assign res_ovf = ovf_c;
    end
  endgenerate
endmodule

module fl_vadd_mlane #(
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [32*LANES-1:0] in_x_data,
  input  logic                in_x_valid,
  output logic                x_ready,
  input  logic [32*LANES-1:0] in_y_data,
  input  logic                in_y_valid,
  output logic                y_ready,
  input  logic                in_last,
`ifdef FL_VADD_SUB_EN
  input  logic                in_sub,
`endif
  output logic [32*LANES-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                ovf,
  output logic [31:0]         beat_count
);
  // vld_pipe[0]=S1 reg, [1]=S2 reg, [2]=output reg (when OUT_REG)
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic                   adv, accept, sub, ovf_q, ovf_now;
  logic [STAGES:0]        vld_pipe, last_pipe;
  logic [LANES-1:0]       lane_ovf;
  logic [LANES-1:0][31:0] y_eff;

`ifdef FL_VADD_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif

  assign out_valid = vld_pipe[STAGES];
  assign out_last  = last_pipe[STAGES];
  assign adv       = !(out_valid && !out_ready);
  assign accept    = in_x_valid && in_y_valid && adv && !rst;
  assign x_ready   = in_y_valid && adv && !rst;
  assign y_ready   = in_x_valid && adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      last_pipe <= {last_pipe[STAGES-1:0], in_last};
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      // subtraction flips y's sign; NaN detection ignores sign so it is unaffected
      assign y_eff[i] = {in_y_data[32*i+31] ^ sub, in_y_data[32*i +: 31]};
      fl_vadd_lane #(.OUT_REG(OUT_REG)) u_lane (
        .clk     (clk),
        .adv     (adv),
        .a       (in_x_data[32*i +: 32]),
        .b       (y_eff[i]),
        .res     (out_data[32*i +: 32]),
        .res_ovf (lane_ovf[i])
      );
    end
  endgenerate

  // ovf rises together with the offending output beat, then sticks
  assign ovf_now = out_valid && (|lane_ovf);
  assign ovf     = !rst && (ovf_q || ovf_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      beat_count <= 32'd0;
    end else begin
      if (ovf_now) ovf_q <= 1'b1;
      if (out_valid && out_ready) beat_count <= beat_count + 32'd1;
    end
  end
endmodule
